// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM array controller.
// SRAM_PARITY_EN adds one even-parity column to the bitline width.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StAct,
    StRec
  } state_e;

`ifdef SRAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  function automatic int unsigned bw_of(input int unsigned cols);
    return cols + PAR_W;
  endfunction

endpackage

// File: rtl/sram_sense_latch.sv
// Per-column differential sense evaluation, gated by the sense-amp enable.
// The controller registers the result on the edge that closes the sense cycle.
module sram_sense_latch #(
  parameter int unsigned BW = 8
) (
  input  logic          sa_en_i,
  input  logic [BW-1:0] bl_i,
  input  logic [BW-1:0] br_i,
  output logic [BW-1:0] data_o,
  output logic          undev_o
);

  always_comb begin
    data_o  = '0;
    undev_o = 1'b0;
    if (sa_en_i) begin
      data_o  = bl_i & ~br_i;
      // A column whose BL and BR sit at the same level never developed a differential.
      undev_o = |(bl_i ~^ br_i);
    end
  end

endmodule

// File: rtl/sram_array_ctrl.sv
// Precharge/access/sense/recovery sequencer for a ROWS x COLS 6T SRAM array.
// Define SRAM_PARITY_EN to store and check an even-parity column.
module sram_array_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ROWS    = 16,
  parameter int unsigned COLS    = 8,
  parameter int unsigned AW      = 4,
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned ACT_CYC = 3,
  localparam int unsigned BW     = bw_of(COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_perr,
  output logic [ROWS-1:0] wl,
  output logic            pre_en,
  output logic            bl_oe,
  output logic [BW-1:0]   bl_out,
  output logic [BW-1:0]   br_out,
  input  logic [BW-1:0]   bl_in,
  input  logic [BW-1:0]   br_in,
  output logic            sa_en
);

  localparam int unsigned MaxCyc = (PRE_CYC > ACT_CYC) ? PRE_CYC : ACT_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] PreLast = CntW'(PRE_CYC - 1);
  localparam logic [CntW-1:0] ActLast = CntW'(ACT_CYC - 1);
  localparam logic [AW:0]     RowsW   = (AW + 1)'(ROWS);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] wdata_q, wdata_d;
  logic            bad_q, bad_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_perr_q, rsp_perr_d;
  logic [ROWS-1:0] wl_q, wl_d;
  logic            pre_en_q, pre_en_d;
  logic            bl_oe_q, bl_oe_d;
  logic [BW-1:0]   bl_out_q, bl_out_d;
  logic [BW-1:0]   br_out_q, br_out_d;
  logic            sa_en_q, sa_en_d;

  logic [BW-1:0]   wdata_ext;
  logic [BW-1:0]   sense_data;
  logic            sense_undev;
  logic            sense_done;
  logic            act_ok;

`ifdef SRAM_PARITY_EN
  assign wdata_ext = {^wdata_q, wdata_q};
`else
  assign wdata_ext = wdata_q;
`endif

  sram_sense_latch #(
    .BW (BW)
  ) u_sense (
    .sa_en_i (sa_en_q),
    .bl_i    (bl_in),
    .br_i    (br_in),
    .data_o  (sense_data),
    .undev_o (sense_undev)
  );

  // Sequencer: request capture and phase counting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bad_d      = bad_q;
    sense_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StPre;
          cnt_d   = '0;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bad_d   = ({1'b0, req_addr} >= RowsW);
        end
      end
      StPre: begin
        if (cnt_q == PreLast) begin
          state_d = StAct;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAct: begin
        if (cnt_q == ActLast) begin
          state_d    = StRec;
          cnt_d      = '0;
          sense_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRec: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_comb begin
    act_ok      = (state_d == StAct) && !bad_q;
    req_ready_d = (state_d == StIdle);
    pre_en_d    = (state_d == StPre);
    wl_d        = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      wl_d[i] = act_ok && (addr_q == AW'(i));
    end
    bl_oe_d     = act_ok && we_q;
    bl_out_d    = (act_ok && we_q) ? wdata_ext : '0;
    br_out_d    = (act_ok && we_q) ? ~wdata_ext : '0;
    sa_en_d     = act_ok && !we_q && (cnt_d == ActLast);
    rsp_valid_d = (state_d == StRec);
    rsp_rdata_d = (sense_done && !we_q && !bad_q) ? sense_data[COLS-1:0] : '0;
    rsp_err_d   = sense_done && (bad_q || (!we_q && sense_undev));
`ifdef SRAM_PARITY_EN
    rsp_perr_d  = sense_done && !we_q && !bad_q && (^sense_data);
`else
    rsp_perr_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bad_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_perr_q  <= 1'b0;
      wl_q        <= '0;
      pre_en_q    <= 1'b0;
      bl_oe_q     <= 1'b0;
      bl_out_q    <= '0;
      br_out_q    <= '0;
      sa_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bad_q       <= bad_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_perr_q  <= rsp_perr_d;
      wl_q        <= wl_d;
      pre_en_q    <= pre_en_d;
      bl_oe_q     <= bl_oe_d;
      bl_out_q    <= bl_out_d;
      br_out_q    <= br_out_d;
      sa_en_q     <= sa_en_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_perr  = rsp_perr_q;
  assign wl        = wl_q;
  assign pre_en    = pre_en_q;
  assign bl_oe     = bl_oe_q;
  assign bl_out    = bl_out_q;
  assign br_out    = br_out_q;
  assign sa_en     = sa_en_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed self-checking bench for sram_array_ctrl (default and ROWS=12 instances).
module tb_sram_array_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned COLS = 8;
  localparam int unsigned BW   = bw_of(COLS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, req_we;
  logic [3:0]      req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_err, rsp_perr;
  logic [COLS-1:0] rsp_rdata;
  logic [15:0]     wl;
  logic            pre_en, bl_oe, sa_en;
  logic [BW-1:0]   bl_out, br_out, bl_in, br_in;

  logic            b_valid, b_ready, b_we;
  logic [3:0]      b_addr;
  logic [COLS-1:0] b_wdata;
  logic            b_rsp_valid, b_rsp_err, b_rsp_perr;
  logic [COLS-1:0] b_rsp_rdata;
  logic [11:0]     b_wl;
  logic            b_pre_en, b_bl_oe, b_sa_en;
  logic [BW-1:0]   b_bl_out, b_br_out, b_bl_in, b_br_in;

  int errors = 0;
  int checks = 0;

  sram_array_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_perr  (rsp_perr),
    .wl        (wl),
    .pre_en    (pre_en),
    .bl_oe     (bl_oe),
    .bl_out    (bl_out),
    .br_out    (br_out),
    .bl_in     (bl_in),
    .br_in     (br_in),
    .sa_en     (sa_en)
  );

  sram_array_ctrl #(
    .ROWS (12)
  ) u_dut12 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_valid),
    .req_ready (b_ready),
    .req_we    (b_we),
    .req_addr  (b_addr),
    .req_wdata (b_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .rsp_perr  (b_rsp_perr),
    .wl        (b_wl),
    .pre_en    (b_pre_en),
    .bl_oe     (b_bl_oe),
    .bl_out    (b_bl_out),
    .br_out    (b_br_out),
    .bl_in     (b_bl_in),
    .br_in     (b_br_in),
    .sa_en     (b_sa_en)
  );

  // Bitline pattern a correctly written cell would present (parity column included).
  function automatic logic [BW-1:0] ext(input logic [COLS-1:0] d);
    logic [BW-1:0] r;
    r = '0;
    r[COLS-1:0] = d;
    if (BW > COLS) r[BW-1] = ^d;
    return r;
  endfunction

  // Present a request, wait (bounded) until accepted; returns #1 after the accept edge.
  task automatic issue(input logic we, input logic [3:0] addr, input logic [COLS-1:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL issue_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    bl_in = '0; br_in = '0; b_bl_in = '0; b_br_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wl, pre_en, bl_oe, sa_en, bl_out, br_out, rsp_valid, rsp_rdata, rsp_err, rsp_perr}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wl=%h pre=%b oe=%b sa=%b blo=%h bro=%h v=%b d=%h e=%b p=%b",
               wl, pre_en, bl_oe, sa_en, bl_out, br_out, rsp_valid, rsp_rdata, rsp_err,
               rsp_perr);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_drive;
    issue(1'b1, 4'd5, 8'h5A);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (pre_en !== (c <= 2)) begin
        errors++;
        $display("FAIL wr_pre_en c%0d: got %b, required %b", c, pre_en, (c <= 2));
      end
      checks++;
      if (wl !== ((c >= 3 && c <= 5) ? 16'h0020 : 16'h0000)) begin
        errors++;
        $display("FAIL wr_wl c%0d: got %h", c, wl);
      end
      checks++;
      if (bl_oe !== (c >= 3 && c <= 5)) begin
        errors++;
        $display("FAIL wr_bl_oe c%0d: got %b", c, bl_oe);
      end
      checks++;
      if (rsp_valid !== (c == 6) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL wr_valid_ready c%0d: valid=%b ready=%b", c, rsp_valid, req_ready);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (bl_out !== ext(8'h5A) || br_out !== ~ext(8'h5A)) begin
          errors++;
          $display("FAIL wr_bitlines c%0d: bl=%h br=%h, required %h %h", c, bl_out, br_out,
                   ext(8'h5A), ~ext(8'h5A));
        end
      end
    end
    checks++;
    if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp: rdata=%h err=%b, required 00 0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_write_read;
    issue(1'b1, 4'd3, 8'hA5);
    bl_in = ext(8'hA5);
    br_in = ~ext(8'hA5);
    issue(1'b0, 4'd3, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (sa_en !== (c == 5) || rsp_valid !== (c == 6)) begin
        errors++;
        $display("FAIL rd_timing c%0d: sa_en=%b rsp_valid=%b", c, sa_en, rsp_valid);
      end
      checks++;
      if (bl_oe !== 1'b0 || (pre_en && (wl != '0))) begin
        errors++;
        $display("FAIL rd_drive c%0d: bl_oe=%b pre_en=%b wl=%h", c, bl_oe, pre_en, wl);
      end
    end
    checks++;
    if (rsp_rdata !== 8'hA5 || rsp_err !== 1'b0 || rsp_perr !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: rdata=%h err=%b perr=%b, required a5 0 0", rsp_rdata, rsp_err,
               rsp_perr);
    end
  endtask

  task automatic test_undeveloped;
    bl_in = ext(8'hA5);
    br_in = ~ext(8'hA5);
    br_in[2] = 1'b1;
    issue(1'b0, 4'd7, 8'h00);
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 8'hA1) begin
      errors++;
      $display("FAIL undev: valid=%b err=%b rdata=%h, required 1 1 a1", rsp_valid, rsp_err,
               rsp_rdata);
    end
  endtask

  task automatic test_bad_addr;
    logic wl_seen;
    wl_seen = 1'b0;
    b_bl_in = ext(8'hA5);
    b_br_in = ~ext(8'hA5);
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_ready: got %b, required 1", b_ready);
    end
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd15;
    @(posedge clk);
    #1 b_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (b_wl != '0 || b_bl_oe || b_sa_en) wl_seen = 1'b1;
    end
    checks++;
    if (wl_seen !== 1'b0) begin
      errors++;
      $display("FAIL bad_wl: array was driven, required no wl/bitline/sense activity");
    end
    checks++;
    if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL bad_rsp: valid=%b err=%b rdata=%h, required 1 1 00", b_rsp_valid,
               b_rsp_err, b_rsp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic v_seen;
    v_seen = 1'b0;
    bl_in = ext(8'hC3);
    br_in = ~ext(8'hC3);
    issue(1'b0, 4'd4, 8'h00);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wl, pre_en, bl_oe, sa_en, bl_out, br_out, rsp_valid, rsp_rdata, rsp_err, rsp_perr}
        !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: wl=%h pre=%b oe=%b sa=%b v=%b ready=%b", wl, pre_en,
               bl_oe, sa_en, rsp_valid, req_ready);
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) v_seen = 1'b1;
    end
    checks++;
    if (v_seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_rsp: dropped request produced rsp_valid");
    end
    issue(1'b0, 4'd4, 8'h00);
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recover: valid=%b rdata=%h err=%b, required 1 c3 0", rsp_valid,
               rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, first, second, n;
    first = -1; second = -1; cyc = 0; n = 0;
    bl_in = ext(8'h3C);
    br_in = ~ext(8'h3C);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    while (second < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        n++;
        checks++;
        if (rsp_rdata !== 8'h3C) begin
          errors++;
          $display("FAIL b2b_data: got %h, required 3c", rsp_rdata);
        end
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (second - first !== 7) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles (seen %0d), required 7", second - first, n);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity;
    bl_in = 9'h001;
    br_in = ~9'h001;
    issue(1'b0, 4'd1, 8'h00);
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_perr !== 1'b1 || rsp_rdata !== 8'h01) begin
      errors++;
      $display("FAIL parity_bad: perr=%b rdata=%h, required 1 01", rsp_perr, rsp_rdata);
    end
    bl_in = 9'h101;
    br_in = ~9'h101;
    issue(1'b0, 4'd1, 8'h00);
    repeat (6) @(negedge clk);
    checks++;
    if (rsp_perr !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: perr=%b err=%b, required 0 0", rsp_perr, rsp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_drive();
    test_write_read();
    test_undeveloped();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
`ifdef SRAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
